// File: rtl/wb4_reqbuf.sv
// Wishbone B4 pipelined request buffer: queues upstream requests in a FIFO,
// replays them downstream with a bound on outstanding issues, and returns
// registered acks/read data in order. Aborted cycles have their late acks dropped.
module wb4_reqbuf #(
  parameter int ARCHBITSZ = 16,
  parameter int DEPTH     = 4,
  parameter int MAXPEND   = 4
) (
  input  logic                   wb4_clk_i,
  input  logic                   wb4_rst_i,
  input  logic                   s_wb4_cyc_i,
  input  logic                   s_wb4_stb_i,
  input  logic                   s_wb4_we_i,
  input  logic [ARCHBITSZ-1:0]   s_wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]   s_wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0] s_wb4_sel_i,
  output logic                   s_wb4_stall_o,
  output logic                   s_wb4_ack_o,
  output logic [ARCHBITSZ-1:0]   s_wb4_data_o,
  output logic                   m_wb4_cyc_o,
  output logic                   m_wb4_stb_o,
  output logic                   m_wb4_we_o,
  output logic [ARCHBITSZ-1:0]   m_wb4_addr_o,
  output logic [ARCHBITSZ-1:0]   m_wb4_data_o,
  output logic [ARCHBITSZ/8-1:0] m_wb4_sel_o,
  input  logic                   m_wb4_stall_i,
  input  logic                   m_wb4_ack_i,
  input  logic [ARCHBITSZ-1:0]   m_wb4_data_i
);
  localparam int SELW = ARCHBITSZ/8;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int PW   = $clog2(MAXPEND+1);

  typedef struct packed {
    logic                 we;
    logic [ARCHBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELW-1:0]      sel;
  } req_t;

  req_t                 mem_q [DEPTH];
  req_t                 head;
  logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        pend_q, pend_d, drop_q, drop_d;
  logic                 ack_q, ack_d;
  logic [ARCHBITSZ-1:0] rdat_q, rdat_d;
  logic                 push, issue, ack_eff;

  assign head          = mem_q[rd_q];
  assign s_wb4_stall_o = (cnt_q == CW'(DEPTH));
  assign m_wb4_stb_o   = (cnt_q != '0) && (pend_q < PW'(MAXPEND));
  assign m_wb4_cyc_o   = (cnt_q != '0) || (pend_q != '0);
  assign m_wb4_we_o    = head.we;
  assign m_wb4_addr_o  = head.addr;
  assign m_wb4_data_o  = head.data;
  assign m_wb4_sel_o   = head.sel;
  assign s_wb4_ack_o   = ack_q;
  assign s_wb4_data_o  = rdat_q;

  assign push    = s_wb4_cyc_i & s_wb4_stb_i & ~s_wb4_stall_o;
  assign issue   = m_wb4_stb_o & ~m_wb4_stall_i;
  assign ack_eff = m_wb4_ack_i & (pend_q != '0);

  always_comb begin
    rd_d   = rd_q + AW'(issue);
    wr_d   = wr_q + AW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(issue);
    pend_d = pend_q + PW'(issue) - PW'(ack_eff);
    drop_d = drop_q;
    // Upstream cycle gone: flush the queue and discard every outstanding ack.
    // drop never exceeds pend, so loading it whenever cyc is low is harmless.
    if (!s_wb4_cyc_i) begin
      rd_d   = wr_q;
      cnt_d  = '0;
      drop_d = pend_d;
    end else if ((drop_q != '0) && m_wb4_ack_i) begin
      drop_d = drop_q - PW'(1);
    end
    ack_d  = ack_eff & (drop_q == '0) & s_wb4_cyc_i;
    rdat_d = m_wb4_ack_i ? m_wb4_data_i : rdat_q;
  end

  always_ff @(posedge wb4_clk_i) begin
    if (push) mem_q[wr_q] <= '{s_wb4_we_i, s_wb4_addr_i, s_wb4_data_i, s_wb4_sel_i};
  end

  always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
    if (!wb4_rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      drop_q <= '0;
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      ack_q  <= ack_d;
      rdat_q <= rdat_d;
    end
  end
endmodule

// File: tb/tb_wb4_reqbuf.sv
// Bench for wb4_reqbuf: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based transaction model.
module tb_wb4_reqbuf;
  localparam int DEPTH   = 4;
  localparam int MAXPEND = 3;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
  } req_t;
  typedef struct {
    logic [15:0] addr;
    bit          discard;
  } iss_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        s_cyc = 0, s_stb = 0, s_we = 0;
  logic [15:0] s_addr = 0, s_wdat = 0;
  logic [1:0]  s_sel = 0;
  logic        s_stall, s_ack;
  logic [15:0] s_rdat;
  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_addr, m_wdat;
  logic [1:0]  m_sel;
  logic        m_stall = 0, m_ack = 0;
  logic [15:0] m_rdat = 0;

  int ncmp = 0, nfail = 0, nsack = 0;

  // model state
  req_t        fq[$];
  iss_t        iss_q[$];
  bit          e_ack = 0;
  logic [15:0] e_data = 0;

  always #5 clk = ~clk;

  wb4_reqbuf #(.ARCHBITSZ(16), .DEPTH(DEPTH), .MAXPEND(MAXPEND)) dut (
    .wb4_clk_i(clk), .wb4_rst_i(rst_n),
    .s_wb4_cyc_i(s_cyc), .s_wb4_stb_i(s_stb), .s_wb4_we_i(s_we),
    .s_wb4_addr_i(s_addr), .s_wb4_data_i(s_wdat), .s_wb4_sel_i(s_sel),
    .s_wb4_stall_o(s_stall), .s_wb4_ack_o(s_ack), .s_wb4_data_o(s_rdat),
    .m_wb4_cyc_o(m_cyc), .m_wb4_stb_o(m_stb), .m_wb4_we_o(m_we),
    .m_wb4_addr_o(m_addr), .m_wb4_data_o(m_wdat), .m_wb4_sel_o(m_sel),
    .m_wb4_stall_i(m_stall), .m_wb4_ack_i(m_ack), .m_wb4_data_i(m_rdat)
  );

  function automatic logic [15:0] hsh(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h0137;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave responder: acks return the hashed address of the oldest issued request.
  task automatic set_ack(input bit a);
    m_ack  = a;
    m_rdat = (iss_q.size() != 0) ? hsh(iss_q[0].addr) : 16'hDEAD;
  endtask

  task automatic model_reset();
    fq.delete();
    iss_q.delete();
    e_ack  = 0;
    e_data = '0;
  endtask

  // Transaction-level update for one clock edge with the currently driven inputs.
  task automatic model_step();
    int  sz    = fq.size();
    bit  push  = s_cyc && s_stb && (sz != DEPTH);
    bit  issue = (sz != 0) && (iss_q.size() < MAXPEND) && !m_stall;
    bit  fwd   = 0;
    if (m_ack && iss_q.size() != 0) begin
      fwd = !iss_q[0].discard && s_cyc;
      void'(iss_q.pop_front());
    end
    e_ack = fwd;
    if (m_ack) e_data = m_rdat;
    if (issue) begin
      iss_q.push_back('{fq[0].addr, 1'b0});
      void'(fq.pop_front());
    end
    if (push) fq.push_back('{s_we, s_addr, s_wdat, s_sel});
    if (!s_cyc) begin
      fq.delete();
      foreach (iss_q[i]) iss_q[i].discard = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("s_stall", s_stall, fq.size() == DEPTH);
    chk("m_stb", m_stb, (fq.size() != 0) && (iss_q.size() < MAXPEND));
    chk("m_cyc", m_cyc, (fq.size() != 0) || (iss_q.size() != 0));
    if (fq.size() != 0) chk("m_head", {m_we, m_addr, m_wdat, m_sel}, fq[0]);
    chk("s_ack", s_ack, e_ack);
    chk("s_data", s_rdat, e_data);
    if (s_ack) nsack++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic up(input bit cyc, input bit stb, input bit we, input logic [15:0] a,
                    input logic [15:0] d);
    s_cyc = cyc; s_stb = stb; s_we = we; s_addr = a; s_wdat = d; s_sel = 2'b11;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_s_ack", s_ack, 0);
    chk("rst_s_data", s_rdat, 0);
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_m_stb", m_stb, 0);
    chk("rst_s_stall", s_stall, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tick();

    // 1: single read
    up(1, 1, 0, 16'h0010, 0); tick();
    s_stb = 0;
    chk("t1_m_stb", m_stb, 1);
    chk("t1_m_addr", m_addr, 16'h0010);
    tick();
    m_ack = 1; m_rdat = 16'hBEEF;
    chk("t1_ack_early", s_ack, 0);
    tick();
    m_ack = 0;
    chk("t1_s_ack", s_ack, 1);
    chk("t1_s_data", s_rdat, 16'hBEEF);
    chk("t1_m_cyc", m_cyc, 0);
    s_cyc = 0; tick();

    // 2: fill with downstream stalled, then drain in order
    m_stall = 1;
    for (int i = 0; i < 5; i++) begin
      up(1, 1, 1, 16'(2*i), 16'(100+i));
      chk("t2_stall", s_stall, i == 4);
      tick();
    end
    s_stb = 0; m_stall = 0;
    for (int i = 0; i < 4; i++) begin
      set_ack(i > 0);
      chk("t2_m_stb", m_stb, 1);
      chk("t2_m_addr", m_addr, 16'(2*i));
      tick();
    end
    set_ack(1); tick();
    set_ack(0); tick();
    chk("t2_m_cyc", m_cyc, 0);

    // 3: pend limit
    m_stall = 1;
    for (int i = 0; i < 4; i++) begin up(1, 1, 0, 16'(16'h100 + 2*i), 0); tick(); end
    s_stb = 0; m_stall = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_m_stb_lim", m_stb, 0);
    chk("t3_m_cyc", m_cyc, 1);
    chk("t3_m_addr", m_addr, 16'h0106);
    set_ack(1); tick();
    set_ack(0);
    chk("t3_m_stb_rel", m_stb, 1);
    tick();
    for (int i = 0; i < 3; i++) begin set_ack(1); tick(); end
    set_ack(0); tick();
    chk("t3_idle", m_cyc, 0);

    // 4: push, issue and ack every cycle
    nsack = 0;
    up(1, 1, 0, 16'h0200, 0); tick();
    s_addr = 16'h0202; tick();
    for (int i = 0; i < 16; i++) begin
      s_addr = 16'(16'h0204 + 2*i);
      set_ack(1);
      chk("t4_m_stb", m_stb, 1);
      tick();
    end
    s_stb = 0;
    for (int i = 0; i < 6 && (fq.size() != 0 || iss_q.size() != 0); i++) begin set_ack(1); tick(); end
    set_ack(0); tick(); tick();
    chk("t4_nacks", nsack, 18);

    // 5: abort with 3 issued and 1 queued
    m_stall = 1;
    for (int i = 0; i < 4; i++) begin up(1, 1, 0, 16'(16'h300 + 2*i), 0); tick(); end
    s_stb = 0; m_stall = 0;
    tick(); tick(); tick();
    s_cyc = 0; tick();
    chk("t5_m_stb", m_stb, 0);
    chk("t5_m_cyc", m_cyc, 1);
    s_cyc = 1;
    for (int i = 0; i < 3; i++) begin
      set_ack(1); tick();
      chk("t5_dropped", s_ack, 0);
    end
    set_ack(0);
    chk("t5_m_cyc_end", m_cyc, 0);
    up(1, 1, 0, 16'h0400, 0); tick();
    s_stb = 0; tick();
    m_ack = 1; m_rdat = 16'h1234; tick();
    m_ack = 0;
    chk("t5_s_ack", s_ack, 1);
    chk("t5_s_data", s_rdat, 16'h1234);

    // 6: asynchronous reset mid-transfer (pend=2, count=3)
    up(1, 1, 0, 16'h0500, 0); tick();
    s_addr = 16'h0502; tick();
    s_addr = 16'h0504; tick();
    m_stall = 1;
    s_addr = 16'h0506; tick();
    s_addr = 16'h0508; tick();
    chk("t6_pre_cyc", m_cyc, 1);
    s_stb = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_s_ack", s_ack, 0);
    chk("t6_s_data", s_rdat, 0);
    chk("t6_m_cyc", m_cyc, 0);
    chk("t6_m_stb", m_stb, 0);
    chk("t6_s_stall", s_stall, 0);
    model_reset();
    s_cyc = 0; m_stall = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    up(1, 1, 1, 16'h0600, 16'h5555); tick();
    s_stb = 0; tick();
    m_ack = 1; m_rdat = 16'h0000; tick();
    m_ack = 0;
    chk("t6_wr_ack", s_ack, 1);
    chk("t6_wr_cyc", m_cyc, 0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      s_cyc   = ($urandom_range(0, 99) >= 4);
      s_stb   = ($urandom_range(0, 99) < 60);
      s_we    = 1'($urandom);
      s_addr  = 16'($urandom) & 16'hFFFE;
      s_wdat  = 16'($urandom);
      s_sel   = 2'($urandom);
      m_stall = ($urandom_range(0, 99) < 30);
      if (iss_q.size() != 0) set_ack($urandom_range(0, 99) < 60);
      else set_ack($urandom_range(0, 99) < 3);
      tick();
    end
    up(1, 0, 0, 0, 0); m_stall = 0;
    for (int i = 0; i < 20 && (fq.size() != 0 || iss_q.size() != 0); i++) begin set_ack(1); tick(); end
    set_ack(0); tick();
    chk("rand_idle", m_cyc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/wb4_reqbuf.md
Name: wb4_reqbuf

Overview:
Pipelined Wishbone B4 request buffer placed directly downstream of the PerIntQ-to-WB4 bridge and upstream of WB4 slaves. It accepts requests on a slave port into a DEPTH-entry FIFO and replays them on a master port. It bounds in-flight requests to MAXPEND and returns registered acks and read data upstream in order. It decouples slave stall timing from the bridge and supports aborting a cycle.

Parameters:
ARCHBITSZ, 16, data/address width in bits; sel width is ARCHBITSZ/8.
DEPTH, 4, request FIFO entries; power of 2, at least 2.
MAXPEND, 4, maximum issued-but-unacked requests on the master port; at least 1.

Ports:
wb4_clk_i  in  1  clock; all logic on rising edge.
wb4_rst_i  in  1  reset; asynchronous, active-low.
s_wb4_cyc_i  in  1  upstream cycle.
s_wb4_stb_i  in  1  upstream strobe.
s_wb4_we_i  in  1  upstream write enable.
s_wb4_addr_i  in  ARCHBITSZ  upstream byte address.
s_wb4_data_i  in  ARCHBITSZ  upstream write data.
s_wb4_sel_i  in  ARCHBITSZ/8  upstream byte select.
s_wb4_stall_o  out  1  FIFO full; request not accepted.
s_wb4_ack_o  out  1  registered ack to upstream.
s_wb4_data_o  out  ARCHBITSZ  registered read data to upstream.
m_wb4_cyc_o  out  1  downstream cycle.
m_wb4_stb_o  out  1  downstream strobe.
m_wb4_we_o  out  1  downstream write enable (FIFO head).
m_wb4_addr_o  out  ARCHBITSZ  downstream address (FIFO head).
m_wb4_data_o  out  ARCHBITSZ  downstream write data (FIFO head).
m_wb4_sel_o  out  ARCHBITSZ/8  downstream byte select (FIFO head).
m_wb4_stall_i  in  1  downstream stall.
m_wb4_ack_i  in  1  downstream ack.
m_wb4_data_i  in  ARCHBITSZ  downstream read data.

Behaviour:
- Reset (wb4_rst_i=0, asynchronous) clears FIFO pointers, count, pend counter and drop counter, and sets s_wb4_ack_o=0, s_wb4_data_o=0. Combinational outputs then evaluate to m_wb4_cyc_o=0, m_wb4_stb_o=0, s_wb4_stall_o=0. FIFO storage is not reset.
- FIFO entry: {we, addr, data, sel}. Storage is registered; there is no fall-through.
- push = s_cyc & s_stb & !s_wb4_stall_o.
- s_wb4_stall_o = (count==DEPTH).
- A request pushed into an empty FIFO appears on the m_ port on the next cycle.
- m_wb4_stb_o = (count!=0) & (pend<MAXPEND). m_we/addr/data/sel always show the FIFO head.
- issue = m_stb & !m_wb4_stall_i. Issue pops the head.
- Push and issue in the same cycle leaves count unchanged.
- pend counter (width clog2(MAXPEND+1)): +1 on issue, -1 on m_wb4_ack_i, unchanged when both occur. An ack with pend==0 is ignored and does not underflow.
- m_wb4_cyc_o = (count!=0) | (pend!=0).
- Response path, 1-cycle latency:
  - s_wb4_ack_o <= m_wb4_ack_i & (pend!=0) & (drop==0) & s_wb4_cyc_i.
  - s_wb4_data_o <= m_wb4_data_i whenever m_wb4_ack_i is high; otherwise it holds its value.
- Ordering: acks are returned in issue order. Write acks and read acks are treated identically.
- Abort: on any cycle with s_wb4_cyc_i=0 and count!=0:
  - The FIFO is flushed (count=0, rd=wr).
  - drop <= pend minus any ack arriving that cycle.
  - Each subsequent m_ack while drop!=0 decrements drop and is not forwarded upstream.
  - m_wb4_cyc_o stays high until pend reaches 0.
- If s_wb4_cyc_i deasserts with count==0 and pend!=0, drop <= pend in the same way.
- A new upstream cycle may push while drop!=0. Its acks are forwarded only after drop reaches 0; ordering is preserved because acks return in order.
- Back-to-back operation: with no stalls and single-cycle acks, sustained throughput is one request per cycle.

Test Plan:
1. Single read: push addr 0x0010, sel 2'b11; slave acks 1 cycle after issue with data 0xBEEF -> m_stb high 1 cycle after push; s_ack_o=1 with s_data_o=0xBEEF exactly 1 cycle after m_ack; m_cyc_o drops the following cycle.
2. Fill: DEPTH=4, m_stall_i held 1, push 5 writes back-to-back -> first 4 accepted, s_stall_o=1 on cycle 5. Release stall -> writes issue in order, addresses 0,2,4,6, one per cycle.
3. MAXPEND=2, slave never acks, 3 queued reads -> exactly 2 issued, m_stb_o low with count=1. One ack -> third issues the next cycle.
4. Simultaneous push, issue and ack each cycle for 16 cycles -> count and pend stay constant, 16 s_acks in order, no stall.
5. Abort: 3 issued, 1 queued, s_cyc_i drops -> FIFO flushed, next 3 m_acks produce no s_ack. A new read then completes with s_ack=1 and correct data.
6. Reset asserted mid-transfer (pend=2, count=3) -> all registers and outputs clear immediately, asynchronously. After release, a new write completes normally.
